// File: rtl/memory_tank_delay_line.sv
// Recirculating mercury-tank delay line for the EDSAC store.
// A WORDS*WORD_POS bit serial line advances one digit per f2_clk edge. One
// clear/write/read transfer of a short word or an even-aligned long word is
// serviced at a time, once the addressed slot comes round to the tail.
//
// Handshake: a request is accepted only in IDLE, on an edge where f2_sel is
// high and at least one of f2_clr/f2_in/f2_out is high (priority
// clr > in > out). From the accept edge until the edge leaving DONE,
// f2_busy is high and request levels are ignored. f2_done pulses for exactly
// one cycle at the end. A request level still held in IDLE starts a new
// transfer.
module memory_tank_delay_line #(
  parameter int WORD_POS = 18,
  parameter int WORDS    = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              f2_clk,
  input  logic              f2_rst_n,
  input  logic              f2_sel,
  input  logic [ADDR_W-1:0] f2_addr,
  input  logic              f2_long,
  input  logic              f2_clr,
  input  logic              f2_in,
  input  logic              f2_out,
  input  logic              f2_mib,
  output logic              f2_mob,
  output logic              monitor,
  output logic              f2_busy,
  output logic              f2_done,
  output logic [1:0]        dbg_state
);

  localparam int LEN   = WORDS * WORD_POS;
  localparam int POS_W = $clog2(LEN);
  localparam int CNT_W = $clog2(2 * WORD_POS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_CLR = 2'd0,
    OP_WR  = 2'd1,
    OP_RD  = 2'd2
  } op_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [POS_W-1:0]   start_q, start_d;
  logic [CNT_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   bcnt_q, bcnt_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [LEN-1:0]     line_q, line_d;
  logic               mob_q, mob_d;
  logic               monitor_q;

  logic               tail;
  logic               active;
  logic               nxt;
  logic [ADDR_W-1:0]  addr_eff;

  // Long transfers always start on the even slot of the pair.
  assign addr_eff = f2_long ? (f2_addr & ~ADDR_W'(1)) : f2_addr;
  assign tail     = line_q[LEN-1];

  // Datapath: decide the bit entering the line, advance position, read out.
  always_comb begin
    active = ((state_q == S_WAIT) && (pos_q == start_q)) || (state_q == S_XFER);
    nxt    = tail;
    if (active) begin
      case (op_q)
        OP_CLR:  nxt = 1'b0;
        OP_WR:   nxt = f2_mib;
        default: nxt = tail;
      endcase
    end
    line_d = {line_q[LEN-2:0], nxt};
    if (pos_q == POS_W'(LEN - 1)) begin
      pos_d = '0;
    end else begin
      pos_d = pos_q + POS_W'(1);
    end
    mob_d = (active && (op_q == OP_RD)) ? tail : 1'b0;
  end

  // Transfer sequencing: accept in IDLE, wait for the slot, stream n bits, pulse done.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    start_d = start_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      S_IDLE: begin
        if (f2_sel && (f2_clr || f2_in || f2_out)) begin
          if (f2_clr) begin
            op_d = OP_CLR;
          end else if (f2_in) begin
            op_d = OP_WR;
          end else begin
            op_d = OP_RD;
          end
          start_d = POS_W'(addr_eff) * POS_W'(WORD_POS);
          last_d  = f2_long ? CNT_W'(2 * WORD_POS - 1) : CNT_W'(WORD_POS - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // The matching cycle is itself active bit 0.
        if (pos_q == start_q) begin
          bcnt_d  = CNT_W'(1);
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (bcnt_q == last_q) begin
          state_d = S_DONE;
        end else begin
          bcnt_d = bcnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM and transfer parameter registers.
  always_ff @(posedge f2_clk or negedge f2_rst_n) begin
    if (!f2_rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_CLR;
      start_q <= '0;
      last_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      start_q <= start_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Circulating line, position counter and registered outputs.
  always_ff @(posedge f2_clk or negedge f2_rst_n) begin
    if (!f2_rst_n) begin
      line_q    <= '0;
      pos_q     <= '0;
      mob_q     <= 1'b0;
      monitor_q <= 1'b0;
    end else begin
      line_q    <= line_d;
      pos_q     <= pos_d;
      mob_q     <= mob_d;
      monitor_q <= tail;
    end
  end

  assign f2_mob    = mob_q;
  assign monitor   = monitor_q;
  assign f2_busy   = (state_q != S_IDLE);
  assign f2_done   = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_memory_tank_delay_line.sv
// Bench for memory_tank_delay_line: a small tank (4 slots x 4 digits) for
// directed and randomized transfers, and a default-sized tank for long retention.
module tb_memory_tank_delay_line;

  localparam int WP  = 4;
  localparam int NW  = 4;
  localparam int LEN = WP * NW;
  localparam int BWP  = 18;
  localparam int BLEN = 576;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Edges since the last reset release; slot position of the tail is this mod LEN.
  int edge_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  // ---------------- small tank ----------------
  logic       sel = 0, lng = 0, req_clr = 0, req_in = 0, req_out = 0, mib = 0;
  logic [1:0] addr = '0;
  logic       mob, mon, busy, done;
  logic [1:0] st;

  memory_tank_delay_line #(.WORD_POS(WP), .WORDS(NW), .ADDR_W(2)) dut (
    .f2_clk(clk), .f2_rst_n(rst_n), .f2_sel(sel), .f2_addr(addr), .f2_long(lng),
    .f2_clr(req_clr), .f2_in(req_in), .f2_out(req_out), .f2_mib(mib),
    .f2_mob(mob), .monitor(mon), .f2_busy(busy), .f2_done(done), .dbg_state(st)
  );

  // ---------------- default tank ----------------
  logic       b_sel = 0, b_long = 0, b_clr = 0, b_in = 0, b_out = 0, b_mib = 0;
  logic [4:0] b_addr = 5'd5;
  logic       b_mob, b_mon, b_busy, b_done;
  logic [1:0] b_st;

  memory_tank_delay_line dut_b (
    .f2_clk(clk), .f2_rst_n(rst_n), .f2_sel(b_sel), .f2_addr(b_addr), .f2_long(b_long),
    .f2_clr(b_clr), .f2_in(b_in), .f2_out(b_out), .f2_mib(b_mib),
    .f2_mob(b_mob), .monitor(b_mon), .f2_busy(b_busy), .f2_done(b_done), .dbg_state(b_st)
  );

  // ---------------- reference model ----------------
  logic [WP-1:0] mem [NW];
  int checks = 0;
  int failures = 0;

  function automatic logic mbit(input int p);
    return mem[p / WP][p % WP];
  endfunction

  function automatic logic [7:0] model_read(input int a_in, input bit l);
    logic [7:0] v = '0;
    int a = l ? (a_in & ~1) : a_in;
    int n = l ? 2 * WP : WP;
    for (int k = 0; k < n; k++) v[k] = mbit(a * WP + k);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_check(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_mob", mob, 0);
      chk("idle_monitor", mon, mbit((edge_cnt - 1 + LEN) % LEN));
    end
  endtask

  // One transfer; want_p >= 0 picks the tail position seen right after the accept edge.
  task automatic xfer(input bit c, input bit i, input bit o, input int a_in, input bit l,
                      input logic [7:0] wd, input int want_p, output logic [7:0] rd);
    int a, stp, n, p, w;
    bit is_wr, is_rd;
    @(negedge clk);
    if (want_p >= 0)
      for (int g = 0; g < LEN && ((edge_cnt + 1) % LEN) != want_p; g++) @(negedge clk);
    sel = 1; req_clr = c; req_in = i; req_out = o; addr = 2'(a_in); lng = l;
    @(posedge clk); #1;
    sel = 0; req_clr = 0; req_in = 0; req_out = 0;
    p = edge_cnt % LEN;
    a = l ? (a_in & ~1) : a_in;
    stp = a * WP;
    n = l ? 2 * WP : WP;
    w = (stp - p + LEN) % LEN;
    is_wr = i && !c;
    is_rd = o && !c && !i;
    rd = '0;
    chk("busy_accept", busy, 1);
    for (int r = 0; r <= w + n; r++) begin
      if (r >= w && r < w + n) mib = is_wr ? wd[r - w] : 1'b1;
      else                     mib = 1'($urandom_range(0, 1));
      if (is_rd && r >= w + 1) rd[r - 1 - w] = mob;
      else                     chk("mob_quiet", mob, 0);
      chk("busy_xfer", busy, 1);
      chk("done_time", done, (r == w + n));
      if (r < w + n) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    mib = 0;
    chk("busy_release", busy, 0);
    chk("done_pulse", done, 0);
    for (int k = 0; k < n; k++) begin
      if (c)          mem[(stp + k) / WP][(stp + k) % WP] = 1'b0;
      else if (is_wr) mem[(stp + k) / WP][(stp + k) % WP] = wd[k];
    end
  endtask

  // Short transfer to slot 5 of the default tank.
  task automatic b_xfer(input bit wr, input logic [17:0] wd, output logic [17:0] rd);
    int p, w;
    @(negedge clk);
    b_sel = 1; b_in = wr; b_out = !wr;
    @(posedge clk); #1;
    b_sel = 0; b_in = 0; b_out = 0;
    p = edge_cnt % BLEN;
    w = (5 * BWP - p + BLEN) % BLEN;
    rd = '0;
    chk("b_busy_accept", b_busy, 1);
    for (int r = 0; r <= w + BWP; r++) begin
      if (r >= w && r < w + BWP) b_mib = wr ? wd[r - w] : 1'b1;
      else                       b_mib = 1'b0;
      if (!wr && r >= w + 1) rd[r - 1 - w] = b_mob;
      if (r == w + BWP - 1) chk("b_done_early", b_done, 0);
      if (r == w + BWP)     chk("b_done", b_done, 1);
      if (r < w + BWP) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    chk("b_busy_release", b_busy, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         c;
    bit         i;
    bit         o;
    int         addr;
    bit         lng;
    logic [7:0] wd;
    bit         chk_rd;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[14];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [7:0]  rd;
    logic [7:0]  exp;
    logic [17:0] b_rd;
    logic [17:0] b_pat;

    //             c  i  o  addr lng wd     chk exp
    tbl[0]  = '{0, 0, 1, 2, 0, 8'h00, 1, 8'h00};  // reset contents of slot 2
    tbl[1]  = '{0, 1, 0, 1, 0, 8'h0D, 0, 8'h00};  // digits 1,0,1,1
    tbl[2]  = '{0, 0, 1, 1, 0, 8'h00, 1, 8'h0D};
    tbl[3]  = '{0, 0, 1, 0, 0, 8'h00, 1, 8'h00};
    tbl[4]  = '{0, 0, 1, 2, 0, 8'h00, 1, 8'h00};
    tbl[5]  = '{0, 0, 1, 3, 0, 8'h00, 1, 8'h00};
    tbl[6]  = '{0, 1, 0, 3, 1, 8'hFF, 0, 8'h00};  // odd address long write at the wrap
    tbl[7]  = '{0, 0, 1, 2, 1, 8'h00, 1, 8'hFF};
    tbl[8]  = '{0, 1, 0, 0, 0, 8'h0F, 0, 8'h00};
    tbl[9]  = '{1, 1, 0, 0, 0, 8'h0F, 0, 8'h00};  // clear wins over write
    tbl[10] = '{0, 0, 1, 0, 0, 8'h00, 1, 8'h00};
    tbl[11] = '{0, 1, 1, 1, 0, 8'h06, 0, 8'h00};  // write wins over read
    tbl[12] = '{0, 0, 1, 1, 0, 8'h00, 1, 8'h06};
    tbl[13] = '{0, 0, 1, 1, 1, 8'h00, 1, 8'h60};  // long read of slots 0,1

    for (int s = 0; s < NW; s++) mem[s] = '0;

    // Reset state
    #1;
    chk("rst_mob", mob, 0);
    chk("rst_monitor", mon, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    idle_check(32);

    // Directed table
    for (int t = 0; t < 14; t++) begin
      xfer(tbl[t].c, tbl[t].i, tbl[t].o, tbl[t].addr, tbl[t].lng, tbl[t].wd, -1, rd);
      if (tbl[t].chk_rd) chk($sformatf("vec%0d_read", t), rd, tbl[t].exp);
      idle_check(2);
    end

    // Latency extremes on slot 0: p=1 gives W=15, p=0 gives W=0
    exp = model_read(0, 0);
    xfer(0, 0, 1, 0, 0, 8'h00, 1, rd);
    chk("lat_w15_read", rd, exp);
    xfer(0, 0, 1, 0, 0, 8'h00, 0, rd);
    chk("lat_w0_read", rd, exp);

    // Randomized transfers against the model
    for (int t = 0; t < 40; t++) begin
      bit c, i, o, l;
      int a;
      logic [7:0] wd;
      c  = ($urandom_range(0, 3) == 0);
      i  = 1'($urandom_range(0, 1));
      o  = 1'($urandom_range(0, 1));
      if (!c && !i && !o) o = 1;
      a  = $urandom_range(0, NW - 1);
      l  = 1'($urandom_range(0, 1));
      wd = 8'($urandom);
      exp = model_read(a, l);
      xfer(c, i, o, a, l, wd, -1, rd);
      if (o && !c && !i) chk("rand_read", rd, exp);
      idle_check($urandom_range(0, 6));
    end

    // Unselected tank ignores a held read request
    @(negedge clk);
    sel = 0; req_out = 1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("unsel_busy", busy, 0);
    end
    req_out = 0;
    idle_check(LEN);

    // Reset during XFER of a write to slot 3
    @(negedge clk);
    for (int g = 0; g < LEN && ((edge_cnt + 1) % LEN) != 12; g++) @(negedge clk);
    sel = 1; req_in = 1; addr = 2'd3; lng = 0; mib = 1;
    @(posedge clk); #1;
    sel = 0; req_in = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_pre_rst", busy, 1);
    rst_n = 0;
    #1;
    chk("midrst_mob", mob, 0);
    chk("midrst_monitor", mon, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    mib = 0;
    for (int s = 0; s < NW; s++) mem[s] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    idle_check(2 * LEN);

    // Default-size tank retention over a long idle run
    b_pat = 18'($urandom) | 18'h20001;
    b_xfer(1, b_pat, b_rd);
    repeat (2000) @(posedge clk);
    #1;
    chk("b_idle_busy", b_busy, 0);
    b_xfer(0, 18'h0, b_rd);
    chk("b_retention", b_rd, b_pat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
